// File: rtl/wb_cpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_cpu_arbiter
// Brief   : Multi-channel Wishbone classic master arbiter with bus lock and
//           bus-cycle timeout.
// Rev     : 1.0
// ============================================================================

module wb_cpu_arbiter #(
  parameter int CH_NUM   = 3,
  parameter int ARB_MODE = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH_NUM-1:0]    ch_req,
  input  logic [CH_NUM*30-1:0] ch_addr,
  input  logic [CH_NUM*4-1:0]  ch_sel,
  input  logic [CH_NUM-1:0]    ch_we,
  input  logic [CH_NUM*32-1:0] ch_data_w,
  input  logic [CH_NUM-1:0]    ch_lock,
  output logic [CH_NUM-1:0]    ch_ack,
  output logic [CH_NUM-1:0]    ch_err,
  output logic [31:0]          ch_data_r,
  output logic [CH_NUM-1:0]    grant,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [29:0]          wbm_addr_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_data_o,
  input  logic [31:0]          wbm_data_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i
);

  localparam int IW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] c_TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_BUS    = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;
  localparam logic [1:0] c_LOCKED = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CH_NUM-1:0] grant_q, grant_d, ack_q, ack_d, err_q, err_d;
  logic [31:0]       rdata_q, rdata_d, wdat_q, wdat_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [29:0]       addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;

  logic [29:0]       w_addr [CH_NUM];
  logic [3:0]        w_sel  [CH_NUM];
  logic [31:0]       w_dat  [CH_NUM];
  logic [IW-1:0]     w_win, w_src, w_ptr_nxt;
  logic              w_found, w_timeout;
  logic [CH_NUM-1:0] w_onehot;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_unpack
    assign w_addr[i] = ch_addr[30*i +: 30];
    assign w_sel[i]  = ch_sel[4*i +: 4];
    assign w_dat[i]  = ch_data_w[32*i +: 32];
  end

  // Round-robin scans upward from the pointer with wrap; fixed priority scans from 0.
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    w_win   = '0;
    w_found = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = (ARB_MODE == 1) ? int'(ptr_q) + k : k;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
      cand = idx[IW-1:0];
      if (!w_found && ch_req[cand]) begin
        w_found = 1'b1;
        w_win   = cand;
      end
    end
  end

  assign w_onehot  = {{(CH_NUM-1){1'b0}}, 1'b1} << w_win;
  assign w_src     = (state_q == c_IDLE) ? w_win : owner_q;
  assign w_ptr_nxt = (owner_q == IW'(CH_NUM - 1)) ? '0 : owner_q + 1'b1;
  assign w_timeout = (TIMEOUT != 0) && (cnt_q == c_TO_LAST);

  always_comb begin
    state_d = state_q;  ptr_d  = ptr_q;   owner_d = owner_q; cnt_d  = cnt_q;
    grant_d = grant_q;  ack_d  = '0;      err_d   = '0;      rdata_d = rdata_q;
    cyc_d   = cyc_q;    stb_d  = stb_q;   we_d    = we_q;    addr_d = addr_q;
    sel_d   = sel_q;    wdat_d = wdat_q;
    case (state_q)
      c_IDLE: begin
        if (w_found) begin
          owner_d = w_win;
          grant_d = w_onehot;
        end
      end
      c_BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (wbm_err_i || w_timeout) begin
          stb_d   = 1'b0;
          err_d   = grant_q;
          state_d = c_DONE;
        end else if (wbm_ack_i) begin
          stb_d   = 1'b0;
          ack_d   = grant_q;
          rdata_d = wbm_data_i;
          state_d = c_DONE;
        end
      end
      c_DONE: begin
        if (ch_lock[owner_q] && !(|err_q)) begin
          state_d = c_LOCKED;
        end else begin
          cyc_d   = 1'b0;
          grant_d = '0;
          ptr_d   = w_ptr_nxt;
          state_d = c_IDLE;
        end
      end
      default: begin
        if (!ch_req[owner_q] && !ch_lock[owner_q]) begin
          cyc_d   = 1'b0;
          grant_d = '0;
          ptr_d   = w_ptr_nxt;
          state_d = c_IDLE;
        end
      end
    endcase
    // Shared launch path for a fresh grant and for a locked owner's follow-up request.
    if ((state_q == c_IDLE && w_found) || (state_q == c_LOCKED && ch_req[owner_q])) begin
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      cnt_d   = '0;
      we_d    = ch_we[w_src];
      addr_d  = w_addr[w_src];
      sel_d   = w_sel[w_src];
      wdat_d  = w_dat[w_src];
      state_d = c_BUS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE; ptr_q  <= '0; owner_q <= '0; cnt_q  <= '0;
      grant_q <= '0;     ack_q  <= '0; err_q   <= '0; rdata_q <= '0;
      cyc_q   <= 1'b0;   stb_q  <= 1'b0; we_q  <= 1'b0; addr_q <= '0;
      sel_q   <= '0;     wdat_q <= '0;
    end else begin
      state_q <= state_d; ptr_q  <= ptr_d;  owner_q <= owner_d; cnt_q  <= cnt_d;
      grant_q <= grant_d; ack_q  <= ack_d;  err_q   <= err_d;   rdata_q <= rdata_d;
      cyc_q   <= cyc_d;   stb_q  <= stb_d;  we_q    <= we_d;    addr_q <= addr_d;
      sel_q   <= sel_d;   wdat_q <= wdat_d;
    end
  end

  assign grant      = grant_q;
  assign ch_ack     = ack_q;
  assign ch_err     = err_q;
  assign ch_data_r  = rdata_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = stb_q;
  assign wbm_we_o   = we_q;
  assign wbm_addr_o = addr_q;
  assign wbm_sel_o  = sel_q;
  assign wbm_data_o = wdat_q;
  assign wbm_cti_o  = 3'b000;
  assign wbm_bte_o  = 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_wb_cpu_arbiter.sv
`default_nettype none
// Bench for wb_cpu_arbiter: instance 0 is fixed-priority/TIMEOUT=8, instance 1 is
// round-robin/TIMEOUT=4; directed scenarios followed by randomized traffic.
module tb_wb_cpu_arbiter;
  localparam int N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req [2], we [2], lock [2], ack [2], err [2], gnt [2];
  logic [N*30-1:0] addr [2];
  logic [N*4-1:0]  sel [2];
  logic [N*32-1:0] dw [2];
  logic [31:0]     dr [2], wdo [2], sdata [2];
  logic            cyc [2], stb [2], wwe [2], sack [2], serr [2];
  logic [29:0]     wadr [2];
  logic [2:0]      cti [2];
  logic [1:0]      bte [2];
  logic [3:0]      wsel [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_cpu_arbiter #(.CH_NUM(N), .ARB_MODE(g), .TIMEOUT(g == 0 ? 8 : 4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ch_req(req[g]), .ch_addr(addr[g]), .ch_sel(sel[g]), .ch_we(we[g]),
      .ch_data_w(dw[g]), .ch_lock(lock[g]),
      .ch_ack(ack[g]), .ch_err(err[g]), .ch_data_r(dr[g]), .grant(gnt[g]),
      .wbm_cyc_o(cyc[g]), .wbm_stb_o(stb[g]), .wbm_we_o(wwe[g]), .wbm_addr_o(wadr[g]),
      .wbm_cti_o(cti[g]), .wbm_bte_o(bte[g]), .wbm_sel_o(wsel[g]), .wbm_data_o(wdo[g]),
      .wbm_data_i(sdata[g]), .wbm_ack_i(sack[g]), .wbm_err_i(serr[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string nm, int k, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t actual=%h required=%h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner index (-1 = bus free), whether a strobe is in flight, cycles elapsed on it,
  // and the outcome of a transfer that just finished (0 none, 1 ack, 2 err).
  int          m_own [2], m_ptr [2], m_el [2], m_res [2];
  bit          m_busy [2];
  logic [N-1:0] e_ack [2], e_err [2];
  logic [31:0] e_dr [2], e_dat [2];
  logic [29:0] e_adr [2];
  logic [3:0]  e_sel [2];
  logic        e_we [2];

  function automatic int to_of(int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic int pick(int k);
    for (int j = 0; j < N; j++) begin
      int c;
      c = (k == 1) ? (m_ptr[k] + j) % N : j;
      if (req[k][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset(int k);
    m_own[k] = -1; m_ptr[k] = 0; m_el[k] = 0; m_res[k] = 0; m_busy[k] = 0;
    e_ack[k] = '0; e_err[k] = '0; e_dr[k] = '0; e_dat[k] = '0;
    e_adr[k] = '0; e_sel[k] = '0; e_we[k] = 1'b0;
  endtask

  task automatic launch(int k, int w);
    m_own[k] = w; m_busy[k] = 1; m_el[k] = 0;
    e_adr[k] = addr[k][30*w +: 30];
    e_sel[k] = sel[k][4*w +: 4];
    e_we[k]  = we[k][w];
    e_dat[k] = dw[k][32*w +: 32];
  endtask

  task automatic release_bus(int k);
    m_ptr[k] = (m_own[k] + 1) % N;
    m_own[k] = -1;
  endtask

  task automatic model_step(int k);
    int pr;
    int w;
    pr = m_res[k];
    m_res[k] = 0; e_ack[k] = '0; e_err[k] = '0;
    if (m_own[k] < 0) begin
      w = pick(k);
      if (w >= 0) launch(k, w);
    end else if (m_busy[k]) begin
      m_el[k]++;
      if (serr[k] || m_el[k] == to_of(k)) begin
        m_busy[k] = 0; m_res[k] = 2; e_err[k] = 3'b001 << m_own[k];
      end else if (sack[k]) begin
        m_busy[k] = 0; m_res[k] = 1; e_ack[k] = 3'b001 << m_own[k]; e_dr[k] = sdata[k];
      end
    end else if (pr != 0) begin
      if (!(pr == 1 && lock[k][m_own[k]])) release_bus(k);
    end else begin
      if (req[k][m_own[k]]) launch(k, m_own[k]);
      else if (!lock[k][m_own[k]]) release_bus(k);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) model_reset(k);
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) model_reset(k);
        else model_step(k);
      end
    end
  end

  function automatic logic [10:0] exp_ctl(int k);
    logic [N-1:0] g;
    g = (m_own[k] >= 0) ? (3'b001 << m_own[k]) : 3'b000;
    return {m_own[k] >= 0, m_busy[k], g, e_ack[k], e_err[k]};
  endfunction

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("ctl", k, 64'({cyc[k], stb[k], gnt[k], ack[k], err[k]}), 64'(exp_ctl(k)));
      check("wbm_req", k, 64'({wwe[k], wsel[k], wadr[k]}), 64'({e_we[k], e_sel[k], e_adr[k]}));
      check("wbm_dat", k, 64'({cti[k], bte[k], wdo[k]}), 64'({5'b00000, e_dat[k]}));
      check("rdata", k, 64'(dr[k]), 64'(e_dr[k]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(int k, int c);
    req[k][c]            = 1'b1;
    addr[k][30*c +: 30]  = 30'($urandom);
    sel[k][4*c +: 4]     = 4'($urandom);
    we[k][c]             = 1'($urandom);
    dw[k][32*c +: 32]    = $urandom;
    lock[k][c]           = ($urandom_range(0, 3) == 0);
  endtask

  task automatic slave_step(int k);
    sack[k]  = stb[k] && ($urandom_range(0, 2) == 0);
    serr[k]  = stb[k] && ($urandom_range(0, 11) == 0);
    sdata[k] = $urandom;
  endtask

  task automatic chan_step(int k, bit gen);
    for (int c = 0; c < N; c++) begin
      if (req[k][c] && (ack[k][c] || err[k][c])) begin
        if (gen && $urandom_range(0, 1) == 0) new_req(k, c);
        else req[k][c] = 1'b0;
      end else if (!req[k][c]) begin
        if (lock[k][c] && (!gen || $urandom_range(0, 2) == 0)) lock[k][c] = 1'b0;
        else if (gen && $urandom_range(0, 3) == 0) new_req(k, c);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  stb_n;
    bit  quiet;
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; we[k] = '0; lock[k] = '0; sack[k] = 1'b0; serr[k] = 1'b0;
      sdata[k] = '0;
      for (int c = 0; c < N; c++) begin
        addr[k][30*c +: 30] = 30'($urandom);
        sel[k][4*c +: 4]    = 4'($urandom);
        dw[k][32*c +: 32]   = $urandom;
      end
    end
    #1 rst_n = 1'b0;
    repeat (3) tick;
    for (int k = 0; k < 2; k++) begin
      check("rst_outputs", k, 64'({cyc[k], stb[k], gnt[k], ack[k], err[k], wadr[k]}), 64'(0));
      check("rst_rdata", k, 64'(dr[k]), 64'(0));
    end
    rst_n = 1'b1;
    tick;

    // Fixed priority, two channels requesting together.
    addr[0][30 +: 30] = 30'h1234567;
    req[0] = 3'b110;
    tick;
    check("fp_first_grant", 0, 64'(gnt[0]), 64'(3'b010));
    check("fp_first_addr", 0, 64'({cyc[0], stb[0], wadr[0]}), 64'({2'b11, 30'h1234567}));
    sack[0] = 1'b1; sdata[0] = 32'h0000_1111;
    tick;
    sack[0] = 1'b0;
    check("fp_ack1", 0, 64'({ack[0], stb[0]}), 64'({3'b010, 1'b0}));
    req[0][1] = 1'b0;
    tick;
    check("fp_release", 0, 64'({cyc[0], gnt[0]}), 64'(0));
    tick;
    check("fp_second_grant", 0, 64'(gnt[0]), 64'(3'b100));
    sack[0] = 1'b1;
    tick;
    sack[0] = 1'b0;
    check("fp_ack2", 0, 64'(ack[0]), 64'(3'b100));
    req[0] = '0;
    tick; tick;

    // Read with three wait states.
    we[0][0] = 1'b0; req[0] = 3'b001; stb_n = 0;
    repeat (4) begin tick; stb_n += int'(stb[0]); end
    sack[0] = 1'b1; sdata[0] = 32'hDEADBEEF;
    tick;
    sack[0] = 1'b0; sdata[0] = 32'h0;
    stb_n += int'(stb[0]);
    check("rd_stb_cycles", 0, 64'(stb_n), 64'(4));
    check("rd_ack", 0, 64'({ack[0], dr[0]}), 64'({3'b001, 32'hDEADBEEF}));
    req[0] = '0;
    tick;
    check("rd_ack_single", 0, 64'({ack[0], dr[0]}), 64'({3'b000, 32'hDEADBEEF}));
    tick;

    // Round-robin rotation with all channels requesting.
    sdata[1] = 32'h1234_5678;
    req[1] = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("rr_grant", 1, 64'(gnt[1]), 64'(3'b001 << (i % 3)));
      sack[1] = 1'b1;
      tick;
      sack[1] = 1'b0;
      tick;
    end
    req[1] = '0;

    // Locked owner does two writes while ch1 waits.
    lock[1] = 3'b001; we[1] = 3'b001; req[1] = 3'b001;
    tick;
    check("lk_grant0", 1, 64'(gnt[1]), 64'(3'b001));
    req[1][1] = 1'b1;
    sack[1] = 1'b1;
    tick;
    sack[1] = 1'b0;
    check("lk_ack1", 1, 64'(ack[1]), 64'(3'b001));
    dw[1][31:0] = 32'hCAFE_0002;
    tick;
    check("lk_hold", 1, 64'({cyc[1], stb[1], gnt[1]}), 64'({2'b10, 3'b001}));
    tick;
    check("lk_second", 1, 64'({cyc[1], stb[1], gnt[1], wdo[1]}), 64'({2'b11, 3'b001, 32'hCAFE_0002}));
    sack[1] = 1'b1;
    tick;
    sack[1] = 1'b0;
    check("lk_ack2", 1, 64'(ack[1]), 64'(3'b001));
    req[1][0] = 1'b0;
    tick;
    tick;
    check("lk_still_held", 1, 64'({cyc[1], gnt[1]}), 64'({1'b1, 3'b001}));
    lock[1][0] = 1'b0;
    tick;
    check("lk_drop", 1, 64'({cyc[1], gnt[1]}), 64'(0));
    tick;
    check("lk_ch1_grant", 1, 64'(gnt[1]), 64'(3'b010));
    sack[1] = 1'b1;
    tick;
    sack[1] = 1'b0;
    req[1] = '0;
    tick;

    // Timeout after four bus cycles, then ack+err collision.
    req[1] = 3'b001;
    tick;
    repeat (3) begin
      tick;
      check("to_waiting", 1, 64'({err[1], stb[1]}), 64'({3'b000, 1'b1}));
    end
    tick;
    check("to_err", 1, 64'({err[1], ack[1], stb[1], cyc[1]}), 64'({3'b001, 3'b000, 2'b01}));
    req[1] = '0;
    tick;
    check("to_release", 1, 64'(cyc[1]), 64'(0));
    req[1] = 3'b010;
    tick;
    sack[1] = 1'b1; serr[1] = 1'b1; sdata[1] = 32'hBAD0_BAD0;
    tick;
    sack[1] = 1'b0; serr[1] = 1'b0;
    check("collide_err", 1, 64'({err[1], ack[1], dr[1]}), 64'({3'b010, 3'b000, 32'h1234_5678}));
    req[1] = '0;
    tick; tick;

    // Reset in the middle of a bus cycle.
    req[0] = 3'b001;
    tick;
    check("rb_grant", 0, 64'({cyc[0], gnt[0]}), 64'({1'b1, 3'b001}));
    #2 rst_n = 1'b0;
    #1;
    check("rb_immediate", 0, 64'({cyc[0], stb[0], gnt[0], ack[0], err[0]}), 64'(0));
    tick;
    check("rb_no_ack", 0, 64'({ack[0], err[0], cyc[0]}), 64'(0));
    rst_n = 1'b1;
    tick;
    check("rb_regrant", 0, 64'({cyc[0], stb[0], gnt[0]}), 64'({2'b11, 3'b001}));
    sack[0] = 1'b1;
    tick;
    sack[0] = 1'b0;
    check("rb_ack", 0, 64'(ack[0]), 64'(3'b001));
    req[0] = '0;
    tick; tick;

    // Randomized traffic on both instances.
    repeat (3000) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        slave_step(k);
        chan_step(k, 1'b1);
      end
    end
    quiet = 1'b0;
    for (int i = 0; i < 400 && !quiet; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        slave_step(k);
        chan_step(k, 1'b0);
      end
      quiet = (req[0] == '0) && (req[1] == '0) && !cyc[0] && !cyc[1];
    end
    check("drain", 0, 64'(quiet), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
